// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction loader, the result unloader and the top FSM.
package cpu_pkg;

    typedef enum logic {S_COLLECT, S_SHOW} unload_state_t;

    localparam int unsigned RESULT_W = 16;
    localparam int unsigned BYTE_W   = 8;

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button synchronizer followed by a rising-edge detector; one pulse per press.
module btn_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/result_unloader.sv
// Collects a bit-serial result LSB first, then shows it on the LEDs one byte per button press.
module result_unloader
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = RESULT_W,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned NBYTES     = WIDTH / BYTE_W,
    localparam int unsigned SEL_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1,
    localparam int unsigned CNT_W      = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_valid,
    input  logic              ser_bit,
    output logic              ser_ready,
    input  logic              btn,
    output logic [BYTE_W-1:0] led_out,
    output logic [SEL_W-1:0]  byte_sel,
    output logic              showing,
    output logic              done
);

    unload_state_t               state_q, state_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]            shreg_q, shreg_d;
    logic [SEL_W-1:0]            byte_idx_q, byte_idx_d;
    logic [BYTE_W-1:0]           led_q, led_d;
    logic                        showing_q, showing_d;
    logic                        done_q, done_d;
    logic [NBYTES-1:0][BYTE_W-1:0] shreg_bytes;
    logic                        btn_edge;

    btn_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_edge_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .btn_i  (btn),
        .edge_o (btn_edge)
    );

    assign ser_ready = (state_q == S_COLLECT);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        byte_idx_d  = byte_idx_q;
        done_d      = 1'b0;
        shreg_bytes = '0;

        unique case (state_q)
            S_COLLECT: begin
                if (ser_valid) begin
                    shreg_d = {ser_bit, shreg_q[WIDTH-1:1]};
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        byte_idx_d = '0;
                        state_d    = S_SHOW;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_SHOW: begin
                if (btn_edge) begin
                    if (byte_idx_q == SEL_W'(NBYTES - 1)) begin
                        done_d     = 1'b1;
                        byte_idx_d = '0;
                        state_d    = S_COLLECT;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase

        // Output registers track the next state so they change on the same edge as the FSM.
        showing_d   = (state_d == S_SHOW);
        shreg_bytes = shreg_d;
        led_d       = showing_d ? shreg_bytes[byte_idx_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_COLLECT;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            led_q      <= '0;
            showing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            led_q      <= led_d;
            showing_q  <= showing_d;
            done_q     <= done_d;
        end
    end

    assign led_out  = led_q;
    assign byte_sel = byte_idx_q;
    assign showing  = showing_q;
    assign done     = done_q;

endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor checks them.
module tb_result_unloader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_valid;
    logic       ser_bit;
    logic       ser_ready;
    logic       btn;
    logic [7:0] led_out;
    logic [0:0] byte_sel;
    logic       showing;
    logic       done;

    typedef struct packed {
        logic       done;
        logic       showing;
        logic       sel;
        logic [7:0] led;
    } obs_t;

    obs_t exp_q[$];
    obs_t prev_obs;
    obs_t cur_obs;
    obs_t exp_obs;
    bit   mon_en      = 1'b0;
    bit   mon_started = 1'b0;
    bit   jam         = 1'b0;
    int   n_vec       = 0;
    int   n_miss      = 0;

    result_unloader #(
        .WIDTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_ready (ser_ready),
        .btn       (btn),
        .led_out   (led_out),
        .byte_sel  (byte_sel),
        .showing   (showing),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Any change of the registered outputs is one observed event.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_obs = {done, showing, byte_sel[0], led_out};
            if (!mon_started) begin
                mon_started = 1'b1;
            end else if (cur_obs !== prev_obs) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_event: got done=%b showing=%b sel=%b led=%h, none expected",
                             cur_obs.done, cur_obs.showing, cur_obs.sel, cur_obs.led);
                end else begin
                    exp_obs = exp_q.pop_front();
                    if (cur_obs !== exp_obs) begin
                        n_miss++;
                        $display("FAIL event: got done=%b showing=%b sel=%b led=%h, want done=%b showing=%b sel=%b led=%h",
                                 cur_obs.done, cur_obs.showing, cur_obs.sel, cur_obs.led,
                                 exp_obs.done, exp_obs.showing, exp_obs.sel, exp_obs.led);
                    end
                end
            end
            prev_obs = cur_obs;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (jam) ser_bit = 1'($urandom);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push(input logic d, input logic s, input logic sel, input logic [7:0] led);
        obs_t o;
        o = {d, s, sel, led};
        exp_q.push_back(o);
    endtask

    task automatic send_bits(input logic [15:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ser_valid = 1'b1;
            ser_bit   = w[i];
            step();
        end
        ser_valid = 1'b0;
    endtask

    task automatic press(input int ncyc);
        btn = 1'b1;
        repeat (ncyc) step();
        btn = 1'b0;
        repeat (4) step();
    endtask

    task automatic expect_done();
        push(1'b1, 1'b0, 1'b0, 8'h00);
        push(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_ready;
        rst_n     = 1'b0;
        btn       = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        check("rst_ready", 32'(ser_ready), 32'd1);
        check("rst_led", 32'(led_out), 32'h00);
        check("rst_sel", 32'(byte_sel), 32'd0);
        check("rst_showing", 32'(showing), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        mon_en = 1'b1;
        step();

        // A5C3: low byte appears on the 16th accept.
        push(1'b0, 1'b1, 1'b0, 8'hC3);
        send_bits(16'hA5C3, 0, 15);
        check("show_ready", 32'(ser_ready), 32'd0);
        check("show_led", 32'(led_out), 32'hC3);

        // Held press: update lands 2 edges after the first sample, once only.
        push(1'b0, 1'b1, 1'b1, 8'hA5);
        btn = 1'b1;
        step();
        step();
        check("press_n1_led", 32'(led_out), 32'hC3);
        step();
        check("press_n2_led", 32'(led_out), 32'hA5);
        check("press_n2_sel", 32'(byte_sel), 32'd1);
        repeat (7) step();
        btn = 1'b0;
        repeat (4) step();

        expect_done();
        press(3);
        check("after_done_ready", 32'(ser_ready), 32'd1);
        check("after_done_showing", 32'(showing), 32'd0);

        push(1'b0, 1'b1, 1'b0, 8'h01);
        send_bits(16'h0001, 0, 15);
        push(1'b0, 1'b1, 1'b1, 8'h00);
        press(3);
        expect_done();
        press(3);

        // Button during collect is ignored.
        send_bits(16'h5A3C, 0, 4);
        press(3);
        push(1'b0, 1'b1, 1'b0, 8'h3C);
        send_bits(16'h5A3C, 5, 15);
        push(1'b0, 1'b1, 1'b1, 8'h5A);
        press(3);
        expect_done();
        press(3);

        // Reset mid-collect discards the partial word.
        send_bits(16'hFFFF, 0, 6);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_ready", 32'(ser_ready), 32'd1);
        push(1'b0, 1'b1, 1'b0, 8'h34);
        send_bits(16'h1234, 0, 15);
        push(1'b0, 1'b1, 1'b1, 8'h12);
        press(3);
        expect_done();
        press(3);

        // Valid held with noise throughout show and on the exit cycle.
        push(1'b0, 1'b1, 1'b0, 8'hEF);
        send_bits(16'hBEEF, 0, 15);
        jam       = 1'b1;
        ser_valid = 1'b1;
        push(1'b0, 1'b1, 1'b1, 8'hBE);
        press(3);
        expect_done();
        push(1'b0, 1'b1, 1'b0, 8'h81);
        btn       = 1'b1;
        got_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ser_ready) begin
                got_ready = 1'b1;
                break;
            end
        end
        check("exit_ready_seen", 32'(got_ready), 32'd1);
        jam = 1'b0;
        btn = 1'b0;
        send_bits(16'h6C81, 0, 15);
        push(1'b0, 1'b1, 1'b1, 8'h6C);
        press(3);
        expect_done();
        press(3);

        repeat (5) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
